// File: rtl/scan_capture_pkg.sv
// Shared constants for the seven-segment scan capture block and its scan generator:
// glyph table, FSM state encoding and default settle time.
package scan_capture_pkg;

    localparam int SETTLE_DEFAULT = 4;
    localparam int CNT_W          = 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_e;

    // Active-high segments, bit 6 = a ... bit 0 = g, indexed by hex value.
    localparam logic [6:0] GLYPH [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    function automatic logic [2:0] low_index(input logic [7:0] a);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (!a[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_capture_seg7_to_hex.sv
// Combinational seven-segment glyph to hex decoder; valid is low for any
// pattern that is not one of the sixteen hex glyphs.
module seg7_to_hex
    import scan_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       valid
);

    always_comb begin
        value = '0;
        valid = 1'b0;
        for (int g = 0; g < 16; g++) begin
            if (seg == GLYPH[g]) begin
                value = 4'(g);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scan_capture.sv
// Captures a multiplexed 8-digit seven-segment display scan into a hex frame,
// waiting for each digit's drive to settle before sampling it.
module scan_capture
    import scan_capture_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  anode,
    input  logic [6:0]  seg_n,
    input  logic        dp_n,
    input  logic        clr,
    output logic [31:0] digits,
    output logic [7:0]  dp,
    output logic        frame_valid,
    output logic        bad_anode,
    output logic        bad_glyph
);

    localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      prev_q, prev_d;
    logic [7:0]       seen_q, seen_d;
    logic [31:0]      shadow_q, shadow_d;
    logic [7:0]       dp_shadow_q, dp_shadow_d;
    logic [31:0]      digits_q, digits_d;
    logic [7:0]       dp_q, dp_d;
    logic             frame_valid_q, frame_valid_d;
    logic             bad_anode_q, bad_anode_d;
    logic             bad_glyph_q, bad_glyph_d;

    logic [15:0] cur;
    logic        one_low, multi_low, enter, capture, set_bad_anode;
    logic [2:0]  idx;
    logic [6:0]  seg_on;
    logic [3:0]  dec_value;
    logic        dec_valid;

    assign cur       = {anode, seg_n, dp_n};
    assign one_low   = $onehot(~anode);
    assign multi_low = (anode != 8'hFF) && !one_low;
    assign idx       = low_index(anode);
    assign seg_on    = ~seg_n;

    seg7_to_hex u_dec (
        .seg   (seg_on),
        .value (dec_value),
        .valid (dec_valid)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prev_d        = cur;
        seen_d        = seen_q;
        shadow_d      = shadow_q;
        dp_shadow_d   = dp_shadow_q;
        digits_d      = digits_q;
        dp_d          = dp_q;
        frame_valid_d = 1'b0;
        enter         = 1'b0;
        capture       = 1'b0;
        set_bad_anode = 1'b0;

        case (state_q)
            S_IDLE:   enter = 1'b1;
            S_SETTLE: begin
                if (cur != prev_q) begin
                    enter = 1'b1;
                end else begin
                    cnt_d = (cnt_q >= SETTLE_CNT) ? SETTLE_CNT : cnt_q + 8'd1;
                end
            end
            S_HOLD:   enter = (anode != prev_q[15:8]);
            default:  enter = 1'b1;
        endcase

        // Entry rules shared by IDLE, a disturbed SETTLE and an anode change in HOLD.
        if (enter) begin
            if (one_low) begin
                state_d = S_SETTLE;
                cnt_d   = 8'd1;
            end else begin
                state_d       = S_IDLE;
                cnt_d         = '0;
                set_bad_anode = multi_low;
            end
        end

        capture = (state_d == S_SETTLE) && (cnt_d == SETTLE_CNT);

        if (capture) begin
            state_d                     = S_HOLD;
            shadow_d[{idx, 2'b00} +: 4] = dec_valid ? dec_value : 4'h0;
            dp_shadow_d[idx]            = ~dp_n;
            seen_d                      = seen_q | (8'd1 << idx);
            if (seen_d == 8'hFF) begin
                digits_d      = shadow_d;
                dp_d          = dp_shadow_d;
                frame_valid_d = 1'b1;
                seen_d        = 8'h00;
            end
        end

        bad_anode_d = clr ? 1'b0 : (bad_anode_q | set_bad_anode);
        bad_glyph_d = clr ? 1'b0 : (bad_glyph_q | (capture & ~dec_valid));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            prev_q        <= 16'hFFFF;
            seen_q        <= 8'h00;
            shadow_q      <= 32'h0;
            dp_shadow_q   <= 8'h00;
            digits_q      <= 32'h0;
            dp_q          <= 8'h00;
            frame_valid_q <= 1'b0;
            bad_anode_q   <= 1'b0;
            bad_glyph_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_q        <= prev_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            dp_shadow_q   <= dp_shadow_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            frame_valid_q <= frame_valid_d;
            bad_anode_q   <= bad_anode_d;
            bad_glyph_q   <= bad_glyph_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign frame_valid = frame_valid_q;
    assign bad_anode   = bad_anode_q;
    assign bad_glyph   = bad_glyph_q;

endmodule

// File: tb/tb_scan_capture.sv
// Self-checking bench for scan_capture: scan generator tasks drive the display
// inputs, completed frames are checked against a queue of expected frames.
module tb_scan_capture;
    import scan_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  anode = 8'hFF;
    logic [6:0]  seg_n = 7'h7F;
    logic        dp_n = 1'b1;
    logic        clr = 1'b0;
    logic [31:0] digits;
    logic [7:0]  dp;
    logic        frame_valid;
    logic        bad_anode;
    logic        bad_glyph;

    int vectors = 0;
    int miscompares = 0;
    int frames = 0;
    logic [39:0] exp_q [$];

    scan_capture #(.SETTLE(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .anode       (anode),
        .seg_n       (seg_n),
        .dp_n        (dp_n),
        .clr         (clr),
        .digits      (digits),
        .dp          (dp),
        .frame_valid (frame_valid),
        .bad_anode   (bad_anode),
        .bad_glyph   (bad_glyph)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_valid === 1'b1) begin
            frames++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL frame_unexpected: got digits=%h dp=%h, required no frame", digits, dp);
            end else begin
                logic [39:0] e;
                e = exp_q.pop_front();
                if ({digits, dp} !== e) begin
                    miscompares++;
                    $display("FAIL frame_data: got digits=%h dp=%h, required digits=%h dp=%h",
                             digits, dp, e[39:8], e[7:0]);
                end
            end
        end
    end

    task automatic hold(input logic [7:0] a, input logic [6:0] s, input logic d, input int n);
        anode = a;
        seg_n = s;
        dp_n  = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan_digit(input int i, input logic [3:0] v, input logic dpv);
        logic [7:0] a;
        a = ~(8'h01 << i);
        hold(a, ~GLYPH[v], ~dpv, 6);
    endtask

    task automatic full_scan(input logic [31:0] vals, input logic [7:0] dpm);
        exp_q.push_back({vals, dpm});
        for (int i = 0; i < 8; i++) scan_digit(i, vals[4*i +: 4], dpm[i]);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({digits, dp, frame_valid, bad_anode, bad_glyph} !== 43'h0 ||
            dut.seen_q !== 8'h00 || dut.shadow_q !== 32'h0 || dut.state_q !== S_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got digits=%h dp=%h fv=%b ba=%b bg=%b seen=%h, required all zero",
                     digits, dp, frame_valid, bad_anode, bad_glyph, dut.seen_q);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        hold(8'hFE, 7'b0000001, 1'b0, 3);
        vectors++;
        if (dut.seen_q !== 8'h00) begin
            miscompares++;
            $display("FAIL single_early: got seen=%h, required 00 after 3 cycles", dut.seen_q);
        end
        hold(8'hFE, 7'b0000001, 1'b0, 1);
        vectors++;
        if (dut.seen_q !== 8'h01 || dut.shadow_q[3:0] !== 4'h0 ||
            dut.dp_shadow_q[0] !== 1'b1 || frame_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_capture: got seen=%h slot0=%h dp0=%b fv=%b, required 01 0 1 0",
                     dut.seen_q, dut.shadow_q[3:0], dut.dp_shadow_q[0], frame_valid);
        end
        hold(8'hFF, 7'h7F, 1'b1, 2);
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = frames;
        full_scan(32'h87654321, 8'hA5);
        vectors++;
        if (frames != f0 + 1) begin
            miscompares++;
            $display("FAIL frame_count1: got %0d frames, required 1", frames - f0);
        end
        full_scan(32'hFEDCBA90, 8'h3C);
        hold(8'hFF, 7'h7F, 1'b1, 3);
        vectors++;
        if (frames != f0 + 2 || digits !== 32'hFEDCBA90 || dp !== 8'h3C) begin
            miscompares++;
            $display("FAIL frame_count2: got %0d frames digits=%h dp=%h, required 2 FEDCBA90 3C",
                     frames - f0, digits, dp);
        end
    endtask

    task automatic test_bad_anode();
        pulse_reset();
        hold(8'hFB, ~GLYPH[3], 1'b1, 5);
        hold(8'hFC, ~GLYPH[3], 1'b1, 10);
        vectors++;
        if (bad_anode !== 1'b1 || dut.seen_q !== 8'h04) begin
            miscompares++;
            $display("FAIL bad_anode_set: got ba=%b seen=%h, required 1 04", bad_anode, dut.seen_q);
        end
        clr = 1'b1;
        hold(8'hFF, 7'h7F, 1'b1, 1);
        clr = 1'b0;
        vectors++;
        if (bad_anode !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_anode_clr: got %b, required 0", bad_anode);
        end
        clr = 1'b1;
        hold(8'hFC, 7'h7F, 1'b1, 1);
        clr = 1'b0;
        hold(8'hFF, 7'h7F, 1'b1, 1);
        vectors++;
        if (bad_anode !== 1'b0 || digits !== 32'h0) begin
            miscompares++;
            $display("FAIL clr_priority: got ba=%b digits=%h, required 0 00000000", bad_anode, digits);
        end
    endtask

    task automatic test_settle();
        pulse_reset();
        for (int k = 0; k < 4; k++) hold(8'hFB, (k % 2) ? ~GLYPH[5] : ~GLYPH[6], 1'b1, 3);
        vectors++;
        if (dut.seen_q !== 8'h00) begin
            miscompares++;
            $display("FAIL settle_toggle: got seen=%h, required 00", dut.seen_q);
        end
        hold(8'hFB, ~GLYPH[7], 1'b1, 3);
        vectors++;
        if (dut.seen_q !== 8'h00) begin
            miscompares++;
            $display("FAIL settle_early: got seen=%h, required 00", dut.seen_q);
        end
        hold(8'hFB, ~GLYPH[7], 1'b1, 1);
        vectors++;
        if (dut.seen_q !== 8'h04 || dut.shadow_q[11:8] !== 4'h7) begin
            miscompares++;
            $display("FAIL settle_capture: got seen=%h slot2=%h, required 04 7", dut.seen_q, dut.shadow_q[11:8]);
        end
        hold(8'hFB, ~GLYPH[9], 1'b1, 6);
        vectors++;
        if (dut.seen_q !== 8'h04 || dut.shadow_q[11:8] !== 4'h7 || dut.state_q !== S_HOLD) begin
            miscompares++;
            $display("FAIL settle_hold: got seen=%h slot2=%h state=%0d, required 04 7 HOLD",
                     dut.seen_q, dut.shadow_q[11:8], dut.state_q);
        end
        hold(8'hFF, 7'h7F, 1'b1, 2);
    endtask

    task automatic test_bad_glyph();
        int f0;
        pulse_reset();
        hold(8'hDF, ~GLYPH[9], 1'b1, 5);
        vectors++;
        if (dut.shadow_q[23:20] !== 4'h9 || dut.seen_q !== 8'h20 || bad_glyph !== 1'b0) begin
            miscompares++;
            $display("FAIL glyph_good: got slot5=%h seen=%h bg=%b, required 9 20 0",
                     dut.shadow_q[23:20], dut.seen_q, bad_glyph);
        end
        hold(8'hFF, 7'h7F, 1'b1, 2);
        hold(8'hDF, 7'b1111110, 1'b0, 5);
        vectors++;
        if (dut.shadow_q[23:20] !== 4'h0 || dut.seen_q !== 8'h20 || bad_glyph !== 1'b1) begin
            miscompares++;
            $display("FAIL glyph_bad: got slot5=%h seen=%h bg=%b, required 0 20 1",
                     dut.shadow_q[23:20], dut.seen_q, bad_glyph);
        end
        f0 = frames;
        exp_q.push_back({32'hAB0CDEF1, 8'h20});
        for (int i = 0; i < 8; i++) begin
            if (i != 5) scan_digit(i, 4'(32'hAB0CDEF1 >> (4*i)), 1'b0);
        end
        clr = 1'b1;
        hold(8'hFF, 7'h7F, 1'b1, 1);
        clr = 1'b0;
        hold(8'hFF, 7'h7F, 1'b1, 2);
        vectors++;
        if (frames != f0 + 1 || bad_glyph !== 1'b0 || digits !== 32'hAB0CDEF1) begin
            miscompares++;
            $display("FAIL glyph_frame: got frames=%0d bg=%b digits=%h, required 1 0 AB0CDEF1",
                     frames - f0, bad_glyph, digits);
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        for (int i = 0; i < 5; i++) scan_digit(i, 4'h2, 1'b1);
        reset = 1'b1;
        #1;
        vectors++;
        if (dut.seen_q !== 8'h00 || digits !== 32'h0 || dp !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_async: got seen=%h digits=%h dp=%h, required 00 0 00",
                     dut.seen_q, digits, dp);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold(8'hFF, 7'h7F, 1'b1, 1);
        f0 = frames;
        exp_q.push_back({32'h13579BDF, 8'hFF});
        for (int i = 0; i < 7; i++) scan_digit(i, 4'(32'h13579BDF >> (4*i)), 1'b1);
        vectors++;
        if (frames != f0) begin
            miscompares++;
            $display("FAIL reset_partial: got %0d frames before last digit, required 0", frames - f0);
        end
        scan_digit(7, 4'h1, 1'b1);
        hold(8'hFF, 7'h7F, 1'b1, 3);
        vectors++;
        if (frames != f0 + 1) begin
            miscompares++;
            $display("FAIL reset_frame: got %0d frames, required 1", frames - f0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_bad_anode();
        test_settle();
        test_bad_glyph();
        test_reset_mid();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL frames_missing: got %0d frames outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
